fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters; fixed at 4 in this revision.
REQ-002 Parameter DW, default 8, data width; matches the FIFO data_in width.
REQ-003 Parameter BURST, default 4, maximum beats per grant; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester write request; bit i high means requester i has a beat ready.
REQ-007 req_data  input  NREQ*DW  packed requester data; requester i owns bits [i*DW +: DW].
REQ-008 fifo_full  input  1  FIFO full flag.
REQ-009 gnt  output  NREQ  one-hot beat-accept; bit i high means requester i's beat is written this cycle.
REQ-010 fifo_wr  output  1  write strobe to the FIFO wr input.
REQ-011 fifo_din  output  DW  write data to the FIFO data_in input.
REQ-012 busy  output  1  high while a requester owns the FIFO (GRANT state).
REQ-013 owner  output  2  index of the current or most recent owner.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT, plus registers owner[1:0] and beat_cnt[3:0].
REQ-015 In IDLE with any req bit high: next owner = first set req bit scanning from (owner+1) mod 4 upward with wrap; state -> GRANT; beat_cnt -> 0.
REQ-016 IDLE SHALL enter GRANT even when fifo_full is high; in IDLE fifo_wr = 0 and gnt = 0.
REQ-017 In GRANT, fifo_wr SHALL be combinational: req[owner] & ~fifo_full.
REQ-018 In GRANT, fifo_din SHALL be req_data slice [owner]; gnt[owner] = fifo_wr; all other gnt bits 0.
REQ-019 fifo_din SHALL be 0 whenever fifo_wr = 0.
REQ-020 Each cycle with fifo_wr = 1 SHALL increment beat_cnt by 1.
REQ-021 GRANT -> IDLE when the accepted beat is beat number BURST (beat_cnt = BURST-1 with fifo_wr = 1).
REQ-022 GRANT -> IDLE when req[owner] = 0; no write occurs that cycle.
REQ-023 While in GRANT with fifo_full = 1 and req[owner] = 1, the FSM SHALL stall: no write, beat_cnt held, ownership held.
REQ-024 The owner register SHALL hold its value in IDLE so the next arbitration rotates from it.
REQ-025 Latency: req rising in IDLE at edge t -> busy at t+1; first beat is written in cycle t+1 if fifo_full = 0.
REQ-026 One IDLE cycle SHALL separate consecutive grants (one-cycle arbitration bubble).
REQ-027 Requests by non-owners during GRANT SHALL be ignored, with no gnt, until the next IDLE.
REQ-028 busy SHALL equal (state == GRANT).
REQ-029 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-030 On rst_n low, asynchronously: state = IDLE, owner = 3, beat_cnt = 0.
REQ-031 On rst_n low, all outputs are immediately 0 (fifo_wr, fifo_din, gnt, busy), except owner = 3.
REQ-032 Reset asserted during GRANT SHALL abort the burst; no fifo_wr SHALL be asserted while rst_n is low.
REQ-033 After reset release, the first arbitration SHALL favour requester 0 (scan starts at (3+1) mod 4 = 0).

Verification
REQ-034 Single requester: reset, req = 0001 held, data 0xA0..0xA7, fifo_full = 0 -> beats 0xA0-0xA3 written; 1 idle cycle; beats 0xA4-0xA7 written; gnt = 0001 on every write.
REQ-035 Round-robin: req = 1111 held, BURST = 4 -> owners 0,1,2,3,0 in order; exactly 4 writes per grant; 1 idle cycle between grants.
REQ-036 Full stall: owner 2 mid-burst after 2 beats; fifo_full = 1 for 5 cycles -> fifo_wr = 0 and busy = 1 throughout; after fifo_full = 0, 2 more beats from owner 2, then IDLE.
REQ-037 Early release: owner 1, req[1] drops after 2 beats -> IDLE next cycle; next grant goes to the lowest set req bit at index >= 2 (wrapping).
REQ-038 Reset mid-burst: assert rst_n low in GRANT -> fifo_wr, gnt, busy = 0 in the same cycle; owner = 3; after release with req = 1001 -> owner 0 granted.
REQ-039 Scoreboard check, all tests: a FIFO model sees no write while full; the written data sequence equals each requester's accepted beats in grant order.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that funnels NREQ write requesters into a single FIFO write port.
// An owner keeps the port for up to BURST beats; one idle cycle separates grants.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               fifo_full,
    output logic [NREQ-1:0]    gnt,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_din,
    output logic               busy,
    output logic [1:0]         owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t        state;
    logic [3:0]    beat_cnt;
    logic [1:0]    next_owner;
    logic [DW-1:0] lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DW +: DW];
    end

    // Scan starts one past the previous owner so every requester gets a turn.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        next_owner = owner;
        found      = 1'b0;
        idx        = owner;
        for (int k = 1; k <= NREQ; k++) begin
            idx = owner + 2'(k);
            if (!found && req[idx]) begin
                next_owner = idx;
                found      = 1'b1;
            end
        end
    end

    assign busy    = (state == GRANT);
    assign fifo_wr = busy && req[owner] && !fifo_full;

    always_comb begin
        gnt = '0;
        if (fifo_wr) begin
            gnt[owner] = 1'b1;
        end
    end

    assign fifo_din = fifo_wr ? lane[owner] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 2'd3;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        owner    <= next_owner;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    // A full FIFO with the owner still requesting just stalls.
                    if (!req[owner]) begin
                        state <= IDLE;
                    end else if (fifo_wr) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed burst scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int LOGN  = 8192;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               fifo_full;
    logic [NREQ-1:0]    gnt;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic               busy;
    logic [1:0]         owner;

    fifo_wr_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .BURST(BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .fifo_full(fifo_full),
        .gnt      (gnt),
        .fifo_wr  (fifo_wr),
        .fifo_din (fifo_din),
        .busy     (busy),
        .owner    (owner)
    );

    int n_checks;
    int n_fail;
    int cyc;

    // Reference model state
    bit       m_active;
    int       m_owner;
    int       m_beats;
    logic [7:0] acc [NREQ];

    // Per-cycle log of DUT behaviour, used by the directed checks
    bit         wr_log   [LOGN];
    bit         busy_log [LOGN];
    int         who_log  [LOGN];
    logic [7:0] din_log  [LOGN];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester i streams 0xA0+16*i, +1, +2 ... one value per accepted beat
    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = 8'hA0 + 8'(i * 16) + acc[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic int gnt_index(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (g == NREQ'(1 << i)) r = i;
        end
        return r;
    endfunction

    task automatic compare_cycle();
        bit         e_wr;
        logic [7:0] e_din;
        logic [3:0] e_gnt;
        int         slot;
        slot = cyc % LOGN;
        if (!rst_n) begin
            chk("rst_fifo_wr", fifo_wr, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_din", fifo_din, 0);
            chk("rst_owner", owner, 3);
            m_active = 0;
            m_owner  = 3;
            m_beats  = 0;
            for (int i = 0; i < NREQ; i++) acc[i] = '0;
            wr_log[slot]   = 0;
            busy_log[slot] = 0;
            who_log[slot]  = -1;
            din_log[slot]  = '0;
        end else begin
            e_wr  = m_active && req[m_owner] && !fifo_full;
            e_gnt = e_wr ? 4'(1 << m_owner) : 4'd0;
            e_din = e_wr ? 8'hA0 + 8'(m_owner * 16) + acc[m_owner] : 8'd0;
            chk("busy", busy, 32'(m_active));
            chk("owner", owner, 32'(m_owner));
            chk("fifo_wr", fifo_wr, 32'(e_wr));
            chk("gnt", gnt, 32'(e_gnt));
            chk("fifo_din", fifo_din, 32'(e_din));
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            chk("no_wr_when_full", 32'(fifo_wr && fifo_full), 0);
            wr_log[slot]   = fifo_wr;
            busy_log[slot] = busy;
            who_log[slot]  = gnt_index(gnt);
            din_log[slot]  = fifo_din;
            if (!m_active) begin
                if (req != 0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (!m_active && req[(m_owner + k) % NREQ]) begin
                            m_owner  = (m_owner + k) % NREQ;
                            m_active = 1;
                        end
                    end
                    m_beats = 0;
                end
            end else if (!req[m_owner]) begin
                m_active = 0;
            end else if (e_wr) begin
                acc[m_owner] = acc[m_owner] + 8'd1;
                m_beats++;
                if (m_beats == BURST) m_active = 0;
            end
        end
        cyc++;
    endtask

    function automatic bit wr_at(input int c);
        return wr_log[c % LOGN];
    endfunction

    initial begin
        int t0;
        int t1;
        int n_wr;
        bit stall_ok;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        m_active  = 0;
        m_owner   = 3;
        m_beats   = 0;
        for (int i = 0; i < NREQ; i++) acc[i] = '0;
        rst_n     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    compare_cycle();
                end
            end
            begin
                // Reset state
                do_reset();
                chk("reset_owner", owner, 3);
                chk("reset_busy", busy, 0);
                chk("reset_wr", fifo_wr, 0);
                chk("reset_gnt", gnt, 0);
                chk("reset_din", fifo_din, 0);

                // Single requester: two bursts of four with a bubble
                do_reset();
                step();
                t0  = cyc;
                req = 4'b0001;
                repeat (12) step();
                begin
                    int wc [8];
                    wc = '{1, 2, 3, 4, 6, 7, 8, 9};
                    for (int k = 0; k < 8; k++) begin
                        chk("single_wr", wr_at(t0 + wc[k]), 1);
                        chk("single_data", din_log[(t0 + wc[k]) % LOGN],
                            32'(8'hA0 + 8'(k)));
                        chk("single_gnt", who_log[(t0 + wc[k]) % LOGN], 0);
                    end
                end
                chk("single_bubble_wr", wr_at(t0 + 5), 0);
                chk("single_bubble_busy", busy_log[(t0 + 5) % LOGN], 0);

                // Round-robin with all requesters active
                do_reset();
                step();
                t0  = cyc;
                req = 4'b1111;
                repeat (28) step();
                for (int k = 0; k < 20; k++) begin
                    chk("rr_wr", wr_at(t0 + 1 + k + k / 4), 1);
                    chk("rr_owner", who_log[(t0 + 1 + k + k / 4) % LOGN],
                        (k / 4) % 4);
                end
                for (int g = 1; g <= 4; g++) begin
                    chk("rr_bubble", wr_at(t0 + 5 * g), 0);
                end

                // FIFO full stall in the middle of owner 2's burst
                do_reset();
                step();
                t0  = cyc;
                req = 4'b0100;
                repeat (3) step();
                fifo_full = 1'b1;
                repeat (5) step();
                fifo_full = 1'b0;
                repeat (4) step();
                req = '0;
                step();
                stall_ok = 1;
                for (int c = 3; c <= 7; c++) begin
                    if (wr_at(t0 + c) || !busy_log[(t0 + c) % LOGN])
                        stall_ok = 0;
                end
                chk("stall_hold", stall_ok, 1);
                n_wr = 0;
                for (int c = 0; c <= 10; c++) n_wr += wr_at(t0 + c);
                chk("stall_beats", n_wr, 4);
                chk("stall_beat3", din_log[(t0 + 8) % LOGN], 32'hC2);
                chk("stall_beat4", din_log[(t0 + 9) % LOGN], 32'hC3);
                chk("stall_then_idle", busy_log[(t0 + 10) % LOGN], 0);

                // Early release by owner 1, then rotation to index >= 2
                do_reset();
                step();
                t0  = cyc;
                req = 4'b0010;
                repeat (3) step();
                req = 4'b1001;
                repeat (6) step();
                req = '0;
                step();
                chk("early_wr1", who_log[(t0 + 1) % LOGN], 1);
                chk("early_wr2", who_log[(t0 + 2) % LOGN], 1);
                chk("early_drop_nowr", wr_at(t0 + 3), 0);
                chk("early_idle", busy_log[(t0 + 4) % LOGN], 0);
                chk("early_next_owner", who_log[(t0 + 5) % LOGN], 3);

                // Reset in the middle of a burst
                do_reset();
                step();
                t0  = cyc;
                req = 4'b1111;
                repeat (2) step();
                chk("midrst_pre_wr", fifo_wr, 1);
                rst_n = 1'b0;
                req   = 4'b1001;
                #1;
                chk("midrst_wr", fifo_wr, 0);
                chk("midrst_gnt", gnt, 0);
                chk("midrst_busy", busy, 0);
                chk("midrst_owner", owner, 3);
                repeat (2) step();
                rst_n = 1'b1;
                t1    = cyc;
                repeat (3) step();
                chk("midrst_regrant", who_log[(t1 + 1) % LOGN], 0);

                // Randomized traffic against the model
                do_reset();
                for (int n = 0; n < 3000; n++) begin
                    step();
                    if (!rst_n) rst_n = 1'b1;
                    else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
                    if ($urandom_range(0, 3) == 0) req = 4'($urandom);
                    fifo_full = ($urandom_range(0, 4) == 0);
                end
                step();
                rst_n = 1'b1;
                req   = '0;
                repeat (4) step();
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
